// File: rtl/pim_pkg.sv
// Shared types and helpers for the bit-serial PIM vector-matrix engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pim_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for n <= 1, so callers widen to at least 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Saturate a per-slice popcount to the ADC full-scale code 2^adc_w-1.
  // The result always fits in adc_w+1 bits; callers truncate to that width.
  function automatic int unsigned adc_clamp(input int unsigned cnt, input int adc_w);
    int unsigned lim;
    lim = (32'd1 << adc_w) - 32'd1;
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage

// File: rtl/pim_bitslice_lane.sv
// One column lane: AND the current bit-slice with the column weights, popcount, ADC clamp.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the lane is evaluated every cycle and sampled by the top only in COMPUTE.
module pim_bitslice_lane
  import pim_pkg::*;
#(
  parameter int N_ELEM = 32,
  parameter int ADC_W  = 6
) (
  input  logic [N_ELEM-1:0] slice_i,
  input  logic [N_ELEM-1:0] weight_i,
  output logic [ADC_W:0]    p_o
);

  logic [N_ELEM-1:0] hit;
  int unsigned       cnt;

  assign hit = slice_i & weight_i;

  // Count elements whose slice bit and weight are both set, then clamp to ADC range.
  always_comb begin
    cnt = 0;
    for (int i = 0; i < N_ELEM; i++) begin
      cnt = cnt + {31'd0, hit[i]};
    end
    p_o = (ADC_W+1)'(adc_clamp(cnt, ADC_W));
  end

endmodule

// File: rtl/pim_vecmat_serial.sv
// Bit-serial PIM vector x binary-matrix multiply, one slice per cycle, MSB first, N_COL outputs.
// Latency: handshake in cycle T gives out_valid in cycle T+DATA_W+1; one vector per DATA_W+1 cycles.
// Backpressure: results held in DONE until out_ready; in_ready follows out_ready there, so a new vector can start back-to-back.
module pim_vecmat_serial
  import pim_pkg::*;
#(
  parameter int N_ELEM = 32,
  parameter int DATA_W = 8,
  parameter int N_COL  = 4,
  parameter int ADC_W  = 6,
  parameter int ACC_W  = 16,
  localparam int COL_W = (clog2(N_COL) > 0) ? clog2(N_COL) : 1,
  localparam int K_W   = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_en,
  input  logic [COL_W-1:0]          w_col,
  input  logic [N_ELEM-1:0]         w_data,
  output logic                      w_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_signed,
  input  logic [N_ELEM*DATA_W-1:0]  vector,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_COL*ACC_W-1:0]    data_out,
  output logic                      busy
);

  // The accumulator must hold the largest unsigned sum plus a sign bit.
  if (ACC_W < ADC_W + DATA_W + 1) begin : g_acc_w_check
    $error("pim_vecmat_serial: ACC_W must be at least ADC_W+DATA_W+1");
  end

  state_e                    state_q, state_d;
  logic [N_ELEM-1:0]         w_q    [N_COL];
  logic [N_ELEM*DATA_W-1:0]  vec_q;
  logic                      sgn_q;
  logic [K_W-1:0]            k_q;
  logic [ACC_W-1:0]          acc_q  [N_COL];
  logic [ACC_W-1:0]          acc_d  [N_COL];
  logic [ACC_W-1:0]          dout_q [N_COL];
  logic [ACC_W-1:0]          term   [N_COL];
  logic [ADC_W:0]            p      [N_COL];
  logic [N_ELEM-1:0]         slice;
  logic                      accept;
  logic                      first_slice;
  logic                      last_slice;
  logic                      w_accept;

  assign accept      = in_valid & in_ready;
  assign w_accept    = w_en & w_ready & (32'(w_col) < N_COL);
  assign first_slice = (k_q == K_W'(DATA_W - 1));
  assign last_slice  = (k_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> COMPUTE on a vector, COMPUTE -> DONE after slice 0,
  // DONE -> COMPUTE (back-to-back) or IDLE once the consumer takes the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = in_valid ? COMPUTE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    w_ready   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        w_ready  = 1'b1;
      end
      COMPUTE: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Weight array: written only in IDLE, so a write alongside a vector lands before slice DATA_W-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_COL; c++) begin
        w_q[c] <= '0;
      end
    end else if (w_accept) begin
      w_q[w_col] <= w_data;
    end
  end

  // Gather bit k of every element into the current slice.
  always_comb begin
    slice = '0;
    for (int e = 0; e < N_ELEM; e++) begin
      slice[e] = vec_q[e*DATA_W + int'(k_q)];
    end
  end

  for (genvar c = 0; c < N_COL; c++) begin : g_lane
    pim_bitslice_lane #(
      .N_ELEM (N_ELEM),
      .ADC_W  (ADC_W)
    ) u_lane (
      .slice_i  (slice),
      .weight_i (w_q[c]),
      .p_o      (p[c])
    );

    assign term[c] = ACC_W'(p[c]);
    assign data_out[c*ACC_W +: ACC_W] = dout_q[c];
  end

  // Shift-and-add; the MSB slice carries negative weight for two's complement inputs.
  always_comb begin
    for (int c = 0; c < N_COL; c++) begin
      acc_d[c] = '0;
      if (sgn_q && first_slice) begin
        acc_d[c] = (acc_q[c] << 1) - term[c];
      end else begin
        acc_d[c] = (acc_q[c] << 1) + term[c];
      end
    end
  end

  // Datapath: latch the vector on accept, accumulate per slice, publish results on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q <= '0;
      sgn_q <= 1'b0;
      k_q   <= '0;
      for (int c = 0; c < N_COL; c++) begin
        acc_q[c]  <= '0;
        dout_q[c] <= '0;
      end
    end else if (accept) begin
      vec_q <= vector;
      sgn_q <= in_signed;
      k_q   <= K_W'(DATA_W - 1);
      for (int c = 0; c < N_COL; c++) begin
        acc_q[c] <= '0;
      end
    end else if (state_q == COMPUTE) begin
      k_q <= k_q - K_W'(1);
      for (int c = 0; c < N_COL; c++) begin
        acc_q[c] <= acc_d[c];
        if (last_slice) dout_q[c] <= acc_d[c];
      end
    end
  end

endmodule

// File: doc/pim_vecmat_serial.md
Name: pim_vecmat_serial

Overview:
- Bit-serial processing-in-memory vector–matrix multiply engine.
- Holds an N_COL x N_ELEM binary weight array and accepts one N_ELEM-element vector per transaction.
- Streams one bit-slice per cycle, MSB first, through per-column AND + popcount + ADC-clamp lanes, with a shift-and-add accumulator.
- Next-generation PIM compute tile: parametrised size, multi-column output, valid/ready handshakes and a signed mode.

Parameters:
- N_ELEM, 32, vector elements per transaction.
- DATA_W, 8, bits per vector element; also the number of compute cycles.
- N_COL, 4, weight columns, i.e. number of outputs.
- ADC_W, 6, ADC precision; per-slice popcount clamps to 2^ADC_W-1.
- ACC_W, 16, accumulator and output width per column; ACC_W >= ADC_W+DATA_W+1 is required (elaboration-time check).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- w_en  in  1  weight write strobe.
- w_col  in  clog2(N_COL)  weight column to write.
- w_data  in  N_ELEM  weight bits for that column; bit i pairs with element i.
- w_ready  out  1  a weight write is accepted this cycle.
- in_valid  in  1  vector available.
- in_ready  out  1  engine accepts a vector.
- in_signed  in  1  elements are two's complement; sampled at the input handshake.
- vector  in  N_ELEM*DATA_W  element i = vector[i*DATA_W +: DATA_W].
- out_valid  out  1  results available.
- out_ready  in  1  consumer accepts the results.
- data_out  out  N_COL*ACC_W  column c result = data_out[c*ACC_W +: ACC_W], two's complement.
- busy  out  1  high in COMPUTE.

Behaviour:
- Reset: state IDLE; out_valid=0, data_out=0, busy=0, all weights=0, all accumulators=0. in_ready=1 and w_ready=1 from the first cycle after reset.
- Reset mid-COMPUTE or in DONE: the transaction is abandoned with no output, and weights are cleared.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1 and w_ready=1.
  - If in_valid: latch vector and in_signed, clear accumulators, set slice counter k=DATA_W-1, go to COMPUTE.
  - If w_en and in_valid occur in the same cycle, the write is applied first and is visible to slice DATA_W-1.
- COMPUTE (exactly DATA_W cycles):
  - Per column c: p = min(popcount(slice_k AND W[c]), 2^ADC_W-1), where slice_k = bit k of every element.
  - acc_c <= (acc_c << 1) + s·p, where s = -1 on the first slice (k=DATA_W-1) when signed mode is set, else +1. Arithmetic is in ACC_W two's complement.
  - k decrements each cycle; after k=0, go to DONE and load data_out from the accumulators.
  - in_ready=0 and w_ready=0; w_en is ignored, with no deferred write.
- DONE:
  - out_valid=1; data_out is held stable until out_ready.
  - in_ready = out_ready.
  - On out_ready with no in_valid: go to IDLE, and out_valid drops the next cycle.
  - On out_ready and in_valid in the same cycle: accept the new vector and go directly to COMPUTE (back-to-back, no bubble).
  - w_ready=0 in DONE.
- Latency: input handshake at cycle T gives out_valid at T+DATA_W+1. Throughput is one vector per DATA_W+1 cycles.
- data_out changes only on entry to DONE; out_valid never drops without an out_ready handshake.

Decomposition:
- Shared package pim_pkg holds:
  - state enum {IDLE, COMPUTE, DONE};
  - clog2 function;
  - adc_clamp function (popcount, ADC_W) -> ADC_W+1 bits.
- One sub-module, pim_bitslice_lane: combinational AND + popcount + clamp for one column, instantiated N_COL times.
- The FSM, counter and accumulators stay in the top module.

Test Plan:
- Unsigned basic: W[0]=all ones, W[1]=0, W[2]=even elements, W[3]=element 0 only; all elements=3, unsigned -> data_out col0=96, col1=0, col2=48, col3=3; out_valid at T+9.
- Signed mode: W[0]=all ones; all elements=8'hFF (-1), in_signed=1 -> col0=-32 (16'hFFE0). The same vector unsigned -> 8160.
- ADC clamp, with ADC_W=4: W[0]=all ones, all elements=8'h01 -> slice popcount 32 clamps to 15, col0=15. Elements=8'h80 unsigned -> 15<<7 = 1920.
- Handshake and backpressure:
  - Hold out_ready=0 for 5 cycles: data_out stable, in_ready=0.
  - Then out_ready=1 with in_valid=1: second vector accepted in the same cycle; second result at +9 cycles, no bubble.
- Weight-write rules:
  - w_en during COMPUTE: ignored, result unchanged.
  - w_en plus in_valid in IDLE: the new weights are used.
  - reset asserted at COMPUTE cycle 4: next cycle out_valid=0, in_ready=1, and a rerun with zeroed weights gives all outputs 0.
